// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

   // Arbiter states: IDLE picks a new owner, BURST keeps the current one.
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // Width of each per-requester grant statistics counter.
   localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request starting
// at ptr and wrapping modulo N (N need not be a power of two).
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Walk the requests in priority order ptr, ptr+1, ... and keep the first hit.
   always_comb begin
      int j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[IW'(j)]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-capable arbiter for the single FIFO write port.
// Optional build macro FIFO_ARB_STATS_EN adds per-requester saturating
// grant counters on out_gnt_cnt.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                        in_clk,
   input  logic                        in_rst,
   input  logic [N_REQ-1:0]            in_req,
   input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
   input  logic                        in_full,
   output logic [N_REQ-1:0]            out_gnt,
   output logic                        out_wen,
   output logic [DATA_WIDTH-1:0]       out_wdata,
   output logic                        out_busy,
   output logic [$clog2(N_REQ)-1:0]    out_owner
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [N_REQ*STAT_W-1:0]     out_gnt_cnt
`endif
);

   localparam int OW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t    state_q, state_d;
   logic [OW-1:0] ptr_q, ptr_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [N_REQ-1:0] gnt;
   logic          pick_found;
   logic [OW-1:0] pick_idx;

   // Next index modulo N_REQ (non power-of-two safe).
   function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] x);
      return (x == OW'(N_REQ - 1)) ? '0 : x + OW'(1);
   endfunction

   rr_pick #(
      .N  (N_REQ),
      .IW (OW)
   ) u_pick (
      .req   (in_req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant and next-state decode; full or reset suppress every grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt     = '0;
      cnt_inc = cnt_q + CW'(1);
      if (!in_rst) begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found && !in_full) begin
                  gnt[pick_idx] = 1'b1;
                  owner_d       = pick_idx;
                  cnt_d         = CW'(1);
                  // Single-write bursts rotate immediately and never leave IDLE.
                  if (MAX_BURST == 1) ptr_d = wrap_inc(pick_idx);
                  else                state_d = ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (!in_req[owner_q]) begin
                  // Owner released the port: rotate, no grant this cycle.
                  state_d = ARB_IDLE;
                  ptr_d   = wrap_inc(owner_q);
               end else if (!in_full) begin
                  gnt[owner_q] = 1'b1;
                  cnt_d        = cnt_inc;
                  if (cnt_inc == CW'(MAX_BURST)) begin
                     state_d = ARB_IDLE;
                     ptr_d   = wrap_inc(owner_q);
                  end
               end
               // Full with owner still requesting: stall, hold everything.
            end
            default: state_d = ARB_IDLE;
         endcase
      end
   end

   // Arbitration state registers; reset abandons any ownership.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Write data mux: one-hot grant selects a slice, zero when idle.
   always_comb begin
      out_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) out_wdata = out_wdata | in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign out_gnt   = gnt;
   assign out_wen   = |gnt;
   assign out_busy  = (state_q == ARB_BURST);
   assign out_owner = owner_q;

`ifdef FIFO_ARB_STATS_EN
   for (genvar g = 0; g < N_REQ; g++) begin : g_stat
      logic [STAT_W-1:0] stat_q;
      // Saturating count of accepted writes for this requester.
      always_ff @(posedge in_clk) begin
         if (in_rst)                        stat_q <= '0;
         else if (gnt[g] && (stat_q != '1)) stat_q <= stat_q + STAT_W'(1);
      end
      assign out_gnt_cnt[g*STAT_W +: STAT_W] = stat_q;
   end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the FIFO (write-enable/full pair of fifo_controller plus data memory) among N_REQ requesters. A granted requester may hold the port for a burst of up to MAX_BURST consecutive writes before priority rotates. Grant is computed in the same cycle as the request, so FIFO full status gates writes directly. The block sits between requester logic and the FIFO write side.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, write data width
MAX_BURST, 4, max consecutive writes per ownership (>=1)

Ports:
in_clk  input  1  clock
in_rst  input  1  synchronous reset, active-high
in_req  input  N_REQ  per-requester write request, level
in_data  input  N_REQ*DATA_WIDTH  per-requester data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
in_full  input  1  FIFO full flag
out_gnt  output  N_REQ  one-hot grant, write accepted this cycle
out_wen  output  1  FIFO write enable, equals OR of out_gnt
out_wdata  output  DATA_WIDTH  data of granted requester, 0 when no grant
out_busy  output  1  1 while in BURST state
out_owner  output  $clog2(N_REQ)  current/last owner index

Behaviour:
- Reset (in_rst=1 at edge): state=IDLE, ptr=0, owner=0, cnt=0. While in_rst is high, out_gnt=0, out_wen=0, out_wdata=0.
- Grant is combinational from registered state, in_req, and in_full. A write occurs in cycle t iff out_wen=1 in cycle t. in_full=1 forces out_gnt=0 in every state.
- IDLE: pick the first i with in_req[i]=1, searching ptr, ptr+1, ... mod N_REQ. If found and !in_full, grant i.
  - On that write: owner<=i, cnt<=1.
  - MAX_BURST==1: ptr<=(i+1) mod N_REQ, stay IDLE.
  - Otherwise: go to BURST.
- BURST: grant only owner, iff in_req[owner]=1 and !in_full. Other requests are ignored.
  - Write occurs: cnt<=cnt+1. If cnt+1==MAX_BURST, go IDLE and ptr<=(owner+1) mod N_REQ.
  - in_req[owner]=0: go IDLE, ptr<=(owner+1) mod N_REQ, no grant this cycle.
  - in_full=1 with owner still requesting: stall. Hold state, cnt, and ownership; no grant.
- Requester protocol: in_data must be valid whenever in_req is high. Dropping in_req without a grant is legal.
- Wrap-around: ptr and owner increment mod N_REQ; N_REQ need not be a power of 2.
- cnt width is $clog2(MAX_BURST+1). cnt never exceeds MAX_BURST.
- Reset mid-burst: ownership is abandoned. The next post-reset grant starts from requester 0.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds output port out_gnt_cnt (N_REQ*16 bits), one 16-bit saturating count of writes per requester. Counts clear on in_rst, increment on each grant, and hold at 16'hFFFF.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg: state enum arb_state_t {ARB_IDLE, ARB_BURST}; STAT_W=16 constant.
- Sub-module rr_pick: purely combinational round-robin picker. Inputs req vector and ptr; outputs found and index. Instantiated once in IDLE-path grant logic.

Test Plan:
- Reset then in_req=4'b1111, in_full=0, MAX_BURST=4 -> requester 0 granted 4 consecutive cycles, then 1 for 4, then 2, then 3, then 0 again; out_wen=1 every cycle.
- In IDLE, ptr=2, in_req=4'b0011 -> wraps, grants requester 0; after burst ends, next pick starts at ptr=1.
- Owner 1 mid-burst (cnt=2), in_full=1 for 3 cycles -> out_gnt=0, out_busy=1, cnt stays 2; full drops -> 2 more grants to requester 1, then rotate to 2.
- Owner 3 drops in_req after 1 write -> IDLE next cycle, ptr=0; in_req[0]=1 -> granted the following cycle; out_wdata matches in_data slice 0.
- in_rst asserted during burst of requester 2 -> next cycle out_gnt=0; after release, with in_req=4'b0110, requester 1 is granted first.
- FIFO_ARB_STATS_EN, single requester 0 held with no full, MAX_BURST=1 for 70000 cycles -> out_gnt_cnt[15:0]=16'hFFFF; other slices 0.
